// File: rtl/icache_direct_if.sv
// Fetch-side and memory-controller-side handshake bundle for icache_direct.
// The cache is the slave; the fetch unit / controller environment is the master.
interface icache_direct_if;
  logic        IF_S;
  logic [31:0] IF_pos;
  logic        IF_success;
  logic [31:0] IF_value;
  logic        MC_S;
  logic [31:0] MC_pos;
  logic        MC_success;
  logic [31:0] MC_value;

  modport master (
    output IF_S, IF_pos, MC_success, MC_value,
    input  IF_success, IF_value, MC_S, MC_pos
  );

  modport slave (
    input  IF_S, IF_pos, MC_success, MC_value,
    output IF_success, IF_value, MC_S, MC_pos
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss to the memory controller. Flush drops the request but keeps the arrays.
module icache_direct #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clr,
  icache_direct_if.slave  bus
);

  localparam int NLINES = 1 << INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  state;
  logic [31:2]             lat_pos;
  logic [NLINES-1:0]       valid;
  logic [31:0]             data_mem [NLINES];
  logic [TAG_BITS-1:0]     tag_mem  [NLINES];

  logic [INDEX_BITS-1:0]   req_idx, lat_idx;
  logic [TAG_BITS-1:0]     req_tag, lat_tag;
  logic                    hit, sample, fill;
  logic                    unused_bits;

  assign req_idx = bus.IF_pos[INDEX_BITS+1:2];
  assign req_tag = bus.IF_pos[31:INDEX_BITS+2];
  assign lat_idx = lat_pos[INDEX_BITS+1:2];
  assign lat_tag = lat_pos[31:INDEX_BITS+2];
  assign unused_bits = ^bus.IF_pos[1:0];

  assign hit    = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A response cycle blocks sampling so a held IF_S is not served twice.
  assign sample = rdy && bus.IF_S && !bus.IF_success;
  // The fill lands even under clr or rdy=0; the data is right for lat_pos.
  assign fill   = !rst && (state == MISS) && bus.MC_success;

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[lat_idx] <= bus.MC_value;
      tag_mem[lat_idx]  <= lat_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid          <= '0;
      state          <= IDLE;
      lat_pos        <= '0;
      bus.IF_success <= 1'b0;
      bus.IF_value   <= '0;
      bus.MC_S       <= 1'b0;
      bus.MC_pos     <= '0;
    end else begin
      if (fill) valid[lat_idx] <= 1'b1;
      if (clr) begin
        state          <= IDLE;
        bus.IF_success <= 1'b0;
        bus.MC_S       <= 1'b0;
        bus.MC_pos     <= '0;
      end else if (fill) begin
        state          <= IDLE;
        bus.IF_success <= 1'b1;
        bus.IF_value   <= bus.MC_value;
        bus.MC_S       <= 1'b0;
      end else begin
        bus.IF_success <= 1'b0;
        if (state == IDLE && sample) begin
          if (hit) begin
            bus.IF_success <= 1'b1;
            bus.IF_value   <= data_mem[req_idx];
          end else begin
            state      <= MISS;
            lat_pos    <= bus.IF_pos[31:2];
            bus.MC_S   <= 1'b1;
            bus.MC_pos <= {bus.IF_pos[31:2], 2'b00};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Scenario bench for icache_direct: expected fetch responses are queued when the
// controller reply is driven and checked by a monitor when IF_success pulses.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst, rdy, clr;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_q[$];

  icache_direct_if ifc();

  icache_direct #(.INDEX_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Response scoreboard: every IF_success pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && ifc.IF_success === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got IF_value=%h, expected no response", ifc.IF_value);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ifc.IF_value !== e) begin
          fails++;
          $display("FAIL resp_value: got %h, expected %h", ifc.IF_value, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] val, input int waitn);
    logic [31:0] exp_pos;
    exp_pos = {addr[31:2], 2'b00};
    ifc.IF_S = 1'b1;
    ifc.IF_pos = addr;
    tick();
    tests++;
    if (ifc.MC_S !== 1'b1 || ifc.MC_pos !== exp_pos || ifc.IF_success !== 1'b0) begin
      fails++;
      $display("FAIL miss_req %h: MC_S=%b MC_pos=%h IF_success=%b, expected 1 %h 0",
               addr, ifc.MC_S, ifc.MC_pos, ifc.IF_success, exp_pos);
    end
    ifc.IF_pos = addr ^ 32'h0000_0F00;
    for (int i = 0; i < waitn; i++) begin
      tick();
      tests++;
      if (ifc.MC_S !== 1'b1 || ifc.MC_pos !== exp_pos || ifc.IF_success !== 1'b0) begin
        fails++;
        $display("FAIL miss_hold %h cyc%0d: MC_S=%b MC_pos=%h, expected 1 %h", addr, i,
                 ifc.MC_S, ifc.MC_pos, exp_pos);
      end
    end
    ifc.MC_success = 1'b1;
    ifc.MC_value = val;
    exp_q.push_back(val);
    tick();
    ifc.MC_success = 1'b0;
    ifc.IF_S = 1'b0;
    tests++;
    if (ifc.IF_success !== 1'b1 || ifc.MC_S !== 1'b0) begin
      fails++;
      $display("FAIL miss_fill %h: IF_success=%b MC_S=%b, expected 1 0", addr,
               ifc.IF_success, ifc.MC_S);
    end
    tick();
    tests++;
    if (ifc.MC_S !== 1'b0 || ifc.IF_success !== 1'b0) begin
      fails++;
      $display("FAIL miss_after %h: MC_S=%b IF_success=%b, expected 0 0", addr,
               ifc.MC_S, ifc.IF_success);
    end
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] val);
    ifc.IF_S = 1'b1;
    ifc.IF_pos = addr;
    exp_q.push_back(val);
    tick();
    ifc.IF_S = 1'b0;
    tests++;
    if (ifc.IF_success !== 1'b1 || ifc.MC_S !== 1'b0) begin
      fails++;
      $display("FAIL hit %h: IF_success=%b MC_S=%b, expected 1 0", addr,
               ifc.IF_success, ifc.MC_S);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    ifc.IF_S = 1'b0; ifc.IF_pos = '0; ifc.MC_success = 1'b0; ifc.MC_value = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests++;
    if (ifc.IF_success !== 1'b0 || ifc.IF_value !== 32'h0 || ifc.MC_S !== 1'b0 ||
        ifc.MC_pos !== 32'h0) begin
      fails++;
      $display("FAIL reset: IF_success=%b IF_value=%h MC_S=%b MC_pos=%h, expected all 0",
               ifc.IF_success, ifc.IF_value, ifc.MC_S, ifc.MC_pos);
    end
  endtask

  task automatic test_cold_miss();
    fetch_miss(32'h0000_1004, 32'h00A0_0093, 4);
    tests++;
    if (ifc.IF_value !== 32'h00A0_0093) begin
      fails++;
      $display("FAIL value_hold: got %h, expected 00a00093", ifc.IF_value);
    end
  endtask

  task automatic test_hit();
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
    fetch_hit(32'h0000_1007, 32'h00A0_0093);
  endtask

  task automatic test_back_to_back();
    ifc.IF_S = 1'b1;
    ifc.IF_pos = 32'h0000_1004;
    exp_q.push_back(32'h00A0_0093);
    exp_q.push_back(32'h00A0_0093);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (ifc.IF_success !== ((i % 2) == 0)) begin
        fails++;
        $display("FAIL b2b cyc%0d: IF_success=%b, expected %b", i, ifc.IF_success, (i % 2) == 0);
      end
    end
    ifc.IF_S = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    fetch_miss(32'h0000_1404, 32'hDEAD_0001, 2);
    fetch_hit(32'h0000_1404, 32'hDEAD_0001);
    fetch_miss(32'h0000_1004, 32'h00A0_0093, 1);
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
  endtask

  task automatic test_clr_mid_miss();
    ifc.IF_S = 1'b1;
    ifc.IF_pos = 32'h0000_2000;
    tick();
    tests++;
    if (ifc.MC_S !== 1'b1 || ifc.MC_pos !== 32'h0000_2000) begin
      fails++;
      $display("FAIL clr_miss_req: MC_S=%b MC_pos=%h, expected 1 00002000", ifc.MC_S, ifc.MC_pos);
    end
    repeat (2) tick();
    clr = 1'b1;
    ifc.IF_pos = 32'h0000_1004;
    tick();
    tests++;
    if (ifc.MC_S !== 1'b0 || ifc.MC_pos !== 32'h0 || ifc.IF_success !== 1'b0) begin
      fails++;
      $display("FAIL clr_flush: MC_S=%b MC_pos=%h IF_success=%b, expected 0 0 0",
               ifc.MC_S, ifc.MC_pos, ifc.IF_success);
    end
    // IF_S was held during clr on a cached address: only served after clr drops.
    clr = 1'b0;
    exp_q.push_back(32'h00A0_0093);
    tick();
    ifc.IF_S = 1'b0;
    tests++;
    if (ifc.IF_success !== 1'b1) begin
      fails++;
      $display("FAIL clr_resume: IF_success=%b, expected 1", ifc.IF_success);
    end
    tick();
    fetch_miss(32'h0000_2000, 32'hCAFE_2000, 1);
  endtask

  task automatic test_clr_with_fill();
    ifc.IF_S = 1'b1;
    ifc.IF_pos = 32'h0000_3000;
    tick();
    repeat (2) tick();
    ifc.MC_success = 1'b1;
    ifc.MC_value = 32'h1234_5678;
    clr = 1'b1;
    ifc.IF_S = 1'b0;
    tick();
    ifc.MC_success = 1'b0;
    clr = 1'b0;
    tests++;
    if (ifc.IF_success !== 1'b0 || ifc.MC_S !== 1'b0) begin
      fails++;
      $display("FAIL clr_fill: IF_success=%b MC_S=%b, expected 0 0", ifc.IF_success, ifc.MC_S);
    end
    tick();
    fetch_hit(32'h0000_3000, 32'h1234_5678);
  endtask

  task automatic test_rdy_low();
    rdy = 1'b0;
    ifc.IF_S = 1'b1;
    ifc.IF_pos = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ifc.MC_S !== 1'b0 || ifc.IF_success !== 1'b0) begin
        fails++;
        $display("FAIL rdy_idle cyc%0d: MC_S=%b IF_success=%b, expected 0 0", i,
                 ifc.MC_S, ifc.IF_success);
      end
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    tests++;
    if (ifc.MC_S !== 1'b1 || ifc.MC_pos !== 32'h0000_4000) begin
      fails++;
      $display("FAIL rdy_hold: MC_S=%b MC_pos=%h, expected 1 00004000", ifc.MC_S, ifc.MC_pos);
    end
    ifc.MC_success = 1'b1;
    ifc.MC_value = 32'hBEEF_4000;
    exp_q.push_back(32'hBEEF_4000);
    tick();
    ifc.MC_success = 1'b0;
    ifc.IF_S = 1'b0;
    rdy = 1'b1;
    tests++;
    if (ifc.IF_success !== 1'b1 || ifc.MC_S !== 1'b0) begin
      fails++;
      $display("FAIL rdy_fill: IF_success=%b MC_S=%b, expected 1 0", ifc.IF_success, ifc.MC_S);
    end
    tick();
    fetch_hit(32'h0000_4000, 32'hBEEF_4000);
  endtask

  task automatic test_spurious();
    ifc.MC_success = 1'b1;
    ifc.MC_value = 32'hBAD0_BAD0;
    tick();
    ifc.MC_success = 1'b0;
    tests++;
    if (ifc.IF_success !== 1'b0 || ifc.MC_S !== 1'b0) begin
      fails++;
      $display("FAIL spurious: IF_success=%b MC_S=%b, expected 0 0", ifc.IF_success, ifc.MC_S);
    end
    fetch_hit(32'h0000_4000, 32'hBEEF_4000);
  endtask

  task automatic test_reset_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (ifc.IF_value !== 32'h0) begin
      fails++;
      $display("FAIL rst_value: IF_value=%h, expected 0", ifc.IF_value);
    end
    fetch_miss(32'h0000_1004, 32'h00A0_0095, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_clr_mid_miss();
    test_clr_with_fill();
    test_rdy_low();
    test_spurious();
    test_reset_valid();
    repeat (2) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL resp_missing: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
